ram_1r1w_dp_init: RTL and testbench

Parametrised two-port synchronous RAM: one write port and one read port, usable in the same cycle, with byte-strobed writes. Successor to the team's single-port byte-enable RAM.
- Adds valid/ready handshakes, a read-valid output and write-first same-address bypass.
- Adds a post-reset zero-fill sequencer so contents are defined before first use.
- Serves as CPU data memory and UART buffer storage.

---
 rtl/ram_1r1w_dp_init.sv | 187 ++++++++++++++++++
 tb/tb_ram_1r1w_dp_init.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1r1w_dp_init.sv
// rtl/ram_1r1w_dp_init.sv - two-port byte-strobed RAM with post-reset zero fill
//
// One write port and one read port, usable in the same cycle. After reset a
// sequencer writes zero to every word (one per cycle, Words cycles) before
// either port reports ready. A read and a write to the same address in one
// cycle return write-first data, merged per byte lane.
//
// Build option: define RAM_OUTPUT_REG_EN to add an output register stage
// (read latency 2 instead of 1).

module ram_1r1w_dp_init #(
  parameter int Width = 32,
  parameter int Words = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     init_done_o,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [$clog2(Words)-1:0] wr_addr_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic [Width/8-1:0]       wr_strb_i,
  input  logic                     rd_valid_i,
  output logic                     rd_ready_o,
  input  logic [$clog2(Words)-1:0] rd_addr_i,
  output logic                     rd_valid_o,
  output logic [Width-1:0]         rd_data_o
);

  localparam int Lanes = Width / 8;
  localparam int AddrW = $clog2(Words);

  // Last address swept by the fill sequencer.
  localparam logic [AddrW-1:0] FillLast = AddrW'(Words - 1);

  // Reject configurations the byte-lane logic cannot represent.
  generate
    if ((Width % 8) != 0 || Width < 8) begin : g_bad_width
      $error("ram_1r1w_dp_init: Width must be a non-zero multiple of 8");
    end
    if (Words < 2) begin : g_bad_words
      $error("ram_1r1w_dp_init: Words must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [AddrW-1:0]  fill;

  logic [Width-1:0]  mem [Words];

  logic              wr_fire;
  logic              rd_fire;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              same_addr;
  logic [Width-1:0]  rd_word;

  assign wr_fire   = wr_valid_i & wr_ready_o;
  assign rd_fire   = rd_valid_i & rd_ready_o;
  assign same_addr = (wr_addr_i == rd_addr_i);

  // Address range decode: only a non-power-of-two depth has unused addresses.
  generate
    if (Words == (1 << AddrW)) begin : g_pow2
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [AddrW-1:0] AddrLimit = AddrW'(Words);
      assign wr_in_range = (wr_addr_i < AddrLimit);
      assign rd_in_range = (rd_addr_i < AddrLimit);
    end
  endgenerate

  // Sequencer: sweep the fill counter through INIT, then sit in RUN with all
  // readies held high until the next reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= INIT;
      fill        <= '0;
      init_done_o <= 1'b0;
      wr_ready_o  <= 1'b0;
      rd_ready_o  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (fill == FillLast) begin
            state       <= RUN;
            init_done_o <= 1'b1;
            wr_ready_o  <= 1'b1;
            rd_ready_o  <= 1'b1;
          end else begin
            fill <= fill + 1'b1;
          end
        end
        RUN: begin
          init_done_o <= 1'b1;
          wr_ready_o  <= 1'b1;
          rd_ready_o  <= 1'b1;
        end
        default: begin
          state <= INIT;
          fill  <= '0;
        end
      endcase
    end
  end

  // Storage write: zero-fill while initialising, strobed user writes after.
  // The array itself is never reset; the fill sweep defines its contents.
  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      mem[fill] <= '0;
    end else if (wr_fire && wr_in_range) begin
      for (int k = 0; k < Lanes; k++) begin
        if (wr_strb_i[k]) begin
          mem[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
        end
      end
    end
  end

  // Read word with write-first bypass: strobed lanes of a same-address write
  // replace the stored bytes; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr_i];
      if (wr_fire && same_addr) begin
        for (int k = 0; k < Lanes; k++) begin
          if (wr_strb_i[k]) begin
            rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
          end
        end
      end
    end
  end

`ifdef RAM_OUTPUT_REG_EN
  logic             stage_valid;
  logic [Width-1:0] stage_data;

  // First read stage: capture the (bypassed) read word of an accepted read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= rd_fire;
      if (rd_fire) begin
        stage_data <= rd_word;
      end
    end
  end

  // Output stage: forward valid every cycle, data only when a result leaves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= stage_valid;
      if (stage_valid) begin
        rd_data_o <= stage_data;
      end
    end
  end
`else
  // Single read stage: result one cycle after acceptance, data held otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_fire;
      if (rd_fire) begin
        rd_data_o <= rd_word;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_1r1w_dp_init.sv
// tb/tb_ram_1r1w_dp_init.sv - scoreboard bench for ram_1r1w_dp_init (256 and 200 words)

module tb_ram_1r1w_dp_init;

`ifdef RAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int WORDS_A = 256;
  localparam int WORDS_B = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid;
  logic [7:0]  rd_addr;

  logic        a_init_done, a_wr_ready, a_rd_ready, a_rd_valid;
  logic [31:0] a_rd_data;
  logic        b_init_done, b_wr_ready, b_rd_ready, b_rd_valid;
  logic [31:0] b_rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] qa_data[$];
  int          qa_cyc[$];
  logic [31:0] qb_data[$];
  int          qb_cyc[$];
  logic [31:0] ma[256];
  logic [31:0] mb[256];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  ram_1r1w_dp_init #(.Width(32), .Words(WORDS_A)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .init_done_o(a_init_done),
    .wr_valid_i(wr_valid), .wr_ready_o(a_wr_ready), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .rd_valid_i(rd_valid), .rd_ready_o(a_rd_ready), .rd_addr_i(rd_addr),
    .rd_valid_o(a_rd_valid), .rd_data_o(a_rd_data)
  );

  ram_1r1w_dp_init #(.Width(32), .Words(WORDS_B)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .init_done_o(b_init_done),
    .wr_valid_i(wr_valid), .wr_ready_o(b_wr_ready), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .rd_valid_i(rd_valid), .rd_ready_o(b_rd_ready), .rd_addr_i(rd_addr),
    .rd_valid_o(b_rd_valid), .rd_data_o(b_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
    end
    return r;
  endfunction

  // Scoreboard pop on every read result from either instance.
  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (qa_data.size() == 0) begin
        check_eq("a_spurious_valid", a_rd_valid, 1'b0);
      end else begin
        logic [31:0] e;
        int c;
        e = qa_data.pop_front();
        c = qa_cyc.pop_front();
        check_eq("a_rd_data", a_rd_data, e);
        check_eq("a_latency", cyc - c, LAT);
        last_a = e;
      end
    end
    if (b_rd_valid) begin
      if (qb_data.size() == 0) begin
        check_eq("b_spurious_valid", b_rd_valid, 1'b0);
      end else begin
        logic [31:0] e;
        int c;
        e = qb_data.pop_front();
        c = qb_cyc.pop_front();
        check_eq("b_rd_data", b_rd_data, e);
        check_eq("b_latency", cyc - c, LAT);
        last_b = e;
      end
    end
  end

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One RUN cycle on both instances; expected read data pushed at drive time.
  task automatic do_cycle(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                          input logic [3:0] ws, input logic rv, input logic [7:0] ra);
    logic [31:0] ea, eb;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_strb = ws;
    rd_valid = rv; rd_addr = ra;
    if (rv) begin
      ea = ma[ra];
      if (wv && wa == ra) ea = merge(ea, wd, ws);
      eb = (int'(ra) < WORDS_B) ? mb[ra] : 32'h0;
      if (wv && wa == ra && int'(ra) < WORDS_B) eb = merge(eb, wd, ws);
      qa_data.push_back(ea); qa_cyc.push_back(cyc);
      qb_data.push_back(eb); qb_cyc.push_back(cyc);
    end
    if (wv) begin
      ma[wa] = merge(ma[wa], wd, ws);
      if (int'(wa) < WORDS_B) mb[wa] = merge(mb[wa], wd, ws);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  // Count edges from reset release; requests driven mid-fill must be ignored.
  task automatic run_init();
    for (int i = 1; i <= WORDS_A; i++) begin
      if (i == 100) begin
        wr_valid = 1'b1; wr_addr = 8'd0; wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
        rd_valid = 1'b1; rd_addr = 8'd0;
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      check_eq("a_init_flags", {a_init_done, a_wr_ready, a_rd_ready},
               (i >= WORDS_A) ? 3'b111 : 3'b000);
      check_eq("b_init_flags", {b_init_done, b_wr_ready, b_rd_ready},
               (i >= WORDS_B) ? 3'b111 : 3'b000);
    end
  endtask

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(196, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_valid = 1'b0; rd_addr = '0;
    clear_models();
    idle(3);

    check_eq("rst_init_done", a_init_done, 1'b0);
    check_eq("rst_wr_ready", a_wr_ready, 1'b0);
    check_eq("rst_rd_ready", a_rd_ready, 1'b0);
    check_eq("rst_rd_valid", a_rd_valid, 1'b0);
    check_eq("rst_rd_data", a_rd_data, 32'h0);
    check_eq("rst_b_flags", {b_init_done, b_rd_valid}, 2'b00);

    rst_n = 1'b1;
    run_init();

    // Fresh contents, and the write attempted during fill must not stick.
    do_cycle(0, 0, 0, 0, 1, 8'h10);
    do_cycle(0, 0, 0, 0, 1, 8'h00);

    // Byte-strobed overwrite.
    do_cycle(1, 8'd5, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    do_cycle(1, 8'd5, 32'h1122_3344, 4'b0101, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 8'd5);
    check_eq("model_addr5", ma[5], 32'hDE22_BE44);

    // Same-address write-first bypass, then persistent value.
    do_cycle(1, 8'd7, 32'h1234_5678, 4'b1111, 0, 0);
    do_cycle(1, 8'd7, 32'hAABB_CCDD, 4'b0011, 1, 8'd7);
    do_cycle(0, 0, 0, 0, 1, 8'd7);

    // Different addresses in one cycle, then all-zero strobe.
    do_cycle(1, 8'd9, 32'hCAFE_F00D, 4'b1111, 1, 8'd5);
    do_cycle(0, 0, 0, 0, 1, 8'd9);
    do_cycle(1, 8'd5, 32'hFFFF_FFFF, 4'b0000, 1, 8'd5);
    do_cycle(0, 0, 0, 0, 1, 8'd5);

    // Range boundary: 210 exists only in the 256-word instance.
    do_cycle(1, 8'd210, 32'hFFFF_FFFF, 4'b1111, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 8'd210);
    do_cycle(0, 0, 0, 0, 1, 8'd82);
    do_cycle(0, 0, 0, 0, 1, 8'd10);
    do_cycle(1, 8'd199, 32'h5A5A_5A5A, 4'b1111, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 8'd199);
    do_cycle(1, 8'd200, 32'h0F0F_0F0F, 4'b1111, 1, 8'd200);

    // Back-to-back reads, then held data with valid low.
    do_cycle(1, 8'd1, 32'hA, 4'b1111, 0, 0);
    do_cycle(1, 8'd2, 32'hB, 4'b1111, 0, 0);
    do_cycle(1, 8'd3, 32'hC, 4'b1111, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 8'd1);
    do_cycle(0, 0, 0, 0, 1, 8'd2);
    do_cycle(0, 0, 0, 0, 1, 8'd3);
    idle(4);
    check_eq("a_hold_valid", a_rd_valid, 1'b0);
    check_eq("a_hold_data", a_rd_data, last_a);
    check_eq("b_hold_data", b_rd_data, last_b);
    check_eq("a_last_was_c", last_a, 32'hC);

    // Random stream with a reset pulse in the middle.
    for (int k = 0; k < 100; k++) begin
      if (k == 50) begin
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_a_outs", {a_init_done, a_wr_ready, a_rd_ready, a_rd_valid}, 4'b0);
        check_eq("mid_rst_a_data", a_rd_data, 32'h0);
        check_eq("mid_rst_b_outs", {b_init_done, b_wr_ready, b_rd_ready, b_rd_valid}, 4'b0);
        check_eq("mid_rst_b_data", b_rd_data, 32'h0);
        qa_data.delete(); qa_cyc.delete();
        qb_data.delete(); qb_cyc.delete();
        clear_models();
        idle(2);
        rst_n = 1'b1;
        run_init();
        do_cycle(0, 0, 0, 0, 1, 8'd5);
        do_cycle(0, 0, 0, 0, 1, 8'd7);
      end else begin
        do_cycle(1'($urandom_range(0, 1)), pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), pick_addr());
      end
    end

    idle(6);
    check_eq("a_drain", qa_data.size(), 0);
    check_eq("b_drain", qb_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
